// File: rtl/app_mem_responder.sv
// Memory-side model of a DDR2 controller user interface: 128-bit word store, 4-entry write-data FIFO,
// fixed-latency reads, refresh/ZQ acks. Define APP_RESP_BACKPRESSURE_EN for periodic app_rdy stalls.
module app_mem_responder #(
   parameter int MEM_DEPTH_LOG2 = 8,
   parameter int READ_LATENCY   = 4,
   parameter int CALIB_CYCLES   = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [26:0]  app_addr,
   input  logic [2:0]   app_cmd,
   input  logic         app_en,
   input  logic [127:0] app_wdf_data,
   input  logic [15:0]  app_wdf_mask,
   input  logic         app_wdf_wren,
   input  logic         app_wdf_end,
   output logic         app_rdy,
   output logic         app_wdf_rdy,
   output logic [127:0] app_rd_data,
   output logic         app_rd_data_valid,
   output logic         app_rd_data_end,
   input  logic         app_ref_req,
   input  logic         app_zq_req,
   output logic         app_ref_ack,
   output logic         app_zq_ack,
   output logic         init_calib_complete
);
   localparam int DEPTH = 1 << MEM_DEPTH_LOG2;
   localparam int CW    = $clog2(CALIB_CYCLES + 1);

   logic [127:0]              r_mem [0:DEPTH-1];
   logic [127:0]              r_fifo_data [0:3];
   logic [15:0]               r_fifo_mask [0:3];
   logic [1:0]                r_wr_ptr, r_rd_ptr;
   logic [2:0]                r_count;
   logic                      r_pend;
   logic [MEM_DEPTH_LOG2-1:0] r_pend_idx;
   logic [CW-1:0]             r_calib_cnt;
   logic                      r_calib;
   logic [READ_LATENCY-1:0]   r_rd_vld;
   logic [127:0]              r_rd_pipe [0:READ_LATENCY-2];
   logic [127:0]              r_rd_data;
   logic [1:0]                r_ref_cnt, r_zq_cnt;
   logic                      r_ref_ack, r_zq_ack;

   logic [MEM_DEPTH_LOG2-1:0] w_idx, w_commit_idx;
   logic                      w_stall, w_cmd_acc, w_wr_acc, w_rd_acc, w_push_req, w_fifo_empty;
   logic                      w_commit_pend, w_commit_head, w_commit_byp, w_commit, w_push, w_pop;
   logic [127:0]              w_commit_data;
   logic [15:0]               w_commit_mask;
   logic                      w_unused;

   assign w_unused = app_wdf_end ^ (^app_addr);

`ifdef APP_RESP_BACKPRESSURE_EN
   logic [3:0] r_bp_cnt;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_bp_cnt <= 4'd0;
      else       r_bp_cnt <= r_bp_cnt + 4'd1;
   end
   assign w_stall = (r_bp_cnt >= 4'd12);
`else
   assign w_stall = 1'b0;
`endif

   assign w_idx        = app_addr[3 +: MEM_DEPTH_LOG2];
   assign w_fifo_empty = (r_count == 3'd0);
   assign app_rdy      = r_calib & ~r_pend & ~w_stall;
   assign app_wdf_rdy  = r_calib & (r_count != 3'd4);
   assign w_cmd_acc    = app_en & app_rdy;
   assign w_wr_acc     = w_cmd_acc & (app_cmd == 3'b000);
   assign w_rd_acc     = w_cmd_acc & (app_cmd == 3'b001);
   assign w_push_req   = app_wdf_wren & app_wdf_rdy;

   // A write commits from the FIFO head, or straight from the input bus when the FIFO is empty.
   assign w_commit_pend = r_pend & w_push_req;
   assign w_commit_head = w_wr_acc & ~w_fifo_empty;
   assign w_commit_byp  = w_wr_acc & w_fifo_empty & w_push_req;
   assign w_commit      = w_commit_pend | w_commit_head | w_commit_byp;
   assign w_commit_idx  = r_pend ? r_pend_idx : w_idx;
   assign w_commit_data = w_commit_head ? r_fifo_data[r_rd_ptr] : app_wdf_data;
   assign w_commit_mask = w_commit_head ? r_fifo_mask[r_rd_ptr] : app_wdf_mask;
   assign w_pop         = w_commit_head;
   assign w_push        = w_push_req & ~w_commit_pend & ~w_commit_byp;

   // NOTE: storage arrays carry no reset; memory contents survive reset and the FIFO/pipe
   // entries are qualified by pointers and valid bits that are reset.
   always_ff @(posedge clk) begin
      if (w_commit) begin
         for (int b = 0; b < 16; b++) begin
            if (!w_commit_mask[b]) r_mem[w_commit_idx][b*8 +: 8] <= w_commit_data[b*8 +: 8];
         end
      end
      if (w_push) begin
         r_fifo_data[r_wr_ptr] <= app_wdf_data;
         r_fifo_mask[r_wr_ptr] <= app_wdf_mask;
      end
      r_rd_pipe[0] <= r_mem[w_idx];
      for (int i = 1; i < READ_LATENCY - 1; i++) r_rd_pipe[i] <= r_rd_pipe[i-1];
   end

   // NOTE: all sequential state uses non-blocking assignments so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr    <= 2'd0;
         r_rd_ptr    <= 2'd0;
         r_count     <= 3'd0;
         r_pend      <= 1'b0;
         r_pend_idx  <= '0;
         r_calib_cnt <= '0;
         r_calib     <= 1'b0;
         r_rd_vld    <= '0;
         r_rd_data   <= '0;
         r_ref_cnt   <= 2'd0;
         r_zq_cnt    <= 2'd0;
         r_ref_ack   <= 1'b0;
         r_zq_ack    <= 1'b0;
      end else begin
         if (!r_calib) begin
            if (r_calib_cnt == CW'(CALIB_CYCLES - 1)) r_calib <= 1'b1;
            else                                      r_calib_cnt <= r_calib_cnt + CW'(1);
         end
         if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
         if (w_push && !w_pop)      r_count <= r_count + 3'd1;
         else if (w_pop && !w_push) r_count <= r_count - 3'd1;
         if (w_commit_pend) begin
            r_pend <= 1'b0;
         end else if (w_wr_acc && w_fifo_empty && !w_push_req) begin
            r_pend     <= 1'b1;
            r_pend_idx <= w_idx;
         end
         r_rd_vld <= {r_rd_vld[READ_LATENCY-2:0], w_rd_acc};
         if (r_rd_vld[READ_LATENCY-2]) r_rd_data <= r_rd_pipe[READ_LATENCY-2];
         // Each ack channel stays busy through its ack cycle, so requests in that window are dropped.
         if (r_ref_cnt == 2'd0) begin
            if (app_ref_req) r_ref_cnt <= 2'd1;
         end else if (r_ref_cnt == 2'd1) begin
            r_ref_cnt <= 2'd2;
            r_ref_ack <= 1'b1;
         end else begin
            r_ref_cnt <= 2'd0;
            r_ref_ack <= 1'b0;
         end
         if (r_zq_cnt == 2'd0) begin
            if (app_zq_req) r_zq_cnt <= 2'd1;
         end else if (r_zq_cnt == 2'd1) begin
            r_zq_cnt <= 2'd2;
            r_zq_ack <= 1'b1;
         end else begin
            r_zq_cnt <= 2'd0;
            r_zq_ack <= 1'b0;
         end
      end
   end

   assign app_rd_data         = r_rd_data;
   assign app_rd_data_valid   = r_rd_vld[READ_LATENCY-1];
   assign app_rd_data_end     = r_rd_vld[READ_LATENCY-1];
   assign app_ref_ack         = r_ref_ack;
   assign app_zq_ack          = r_zq_ack;
   assign init_calib_complete = r_calib;
endmodule

// File: tb/tb_app_mem_responder.sv
// Self-checking bench for app_mem_responder: directed vector table, multi-cycle corner sequences
// and randomized traffic against a queue-based reference model.
module tb_app_mem_responder;
   localparam int LAT = 4;
   localparam int CAL = 64;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [26:0]  app_addr = '0;
   logic [2:0]   app_cmd = '0;
   logic         app_en = 1'b0;
   logic [127:0] app_wdf_data = '0;
   logic [15:0]  app_wdf_mask = '0;
   logic         app_wdf_wren = 1'b0;
   logic         app_wdf_end = 1'b0;
   logic         app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data_end;
   logic [127:0] app_rd_data;
   logic         app_ref_req = 1'b0, app_zq_req = 1'b0;
   logic         app_ref_ack, app_zq_ack, init_calib_complete;

   always #5 clk = ~clk;

   app_mem_responder #(.MEM_DEPTH_LOG2(8), .READ_LATENCY(LAT), .CALIB_CYCLES(CAL)) dut (
      .clk(clk), .reset(reset),
      .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
      .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
      .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
      .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy),
      .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
      .app_rd_data_end(app_rd_data_end),
      .app_ref_req(app_ref_req), .app_zq_req(app_zq_req),
      .app_ref_ack(app_ref_ack), .app_zq_ack(app_zq_ack),
      .init_calib_complete(init_calib_complete)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: word array, FIFO queue, pending write, queue of timed read returns.
   typedef struct { logic [127:0] data; logic [15:0] mask; } wd_t;
   typedef struct { int due; logic [127:0] data; } rd_t;
   logic [127:0] m_mem [0:255];
   wd_t          m_fifo[$];
   rd_t          m_rdq[$];
   bit           m_pend = 0;
   int           m_pidx = 0;
   int           cyc = 0;
   logic [127:0] m_last = '0;
   int           ref_due = -10;
   int           zq_due = -10;

   function automatic void commit(input int idx, input wd_t w);
      for (int b = 0; b < 16; b++)
         if (!w.mask[b]) m_mem[idx][b*8 +: 8] = w.data[b*8 +: 8];
   endfunction

   task automatic observe();
      bit ev;
      ev = (m_rdq.size() > 0) && (m_rdq[0].due == cyc);
      check("rd_valid", app_rd_data_valid, ev);
      check("rd_end", app_rd_data_end, ev);
      if (ev) m_last = m_rdq.pop_front().data;
      check("rd_data", app_rd_data, m_last);
      check("ref_ack", app_ref_ack, cyc == ref_due);
      check("zq_ack", app_zq_ack, cyc == zq_due);
      check("calib", init_calib_complete, cyc >= CAL);
   endtask

   // One clock cycle: drive inputs, check ready outputs, advance the model, check registered outputs.
   task automatic cycle(input bit en, input logic [2:0] cmd, input logic [26:0] addr, input bit wren,
                        input logic [127:0] wd, input logic [15:0] wm, input bit rf = 0, input bit zq = 0);
      bit  calib, e_rdy, e_wrdy, push, acc;
      int  idx;
      wd_t w;
      app_en = en; app_cmd = cmd; app_addr = addr; app_wdf_wren = wren;
      app_wdf_data = wd; app_wdf_mask = wm; app_wdf_end = wren;
      app_ref_req = rf; app_zq_req = zq;
      #1;
      calib  = cyc >= CAL;
      e_rdy  = calib && !m_pend;
      e_wrdy = calib && (m_fifo.size() < 4);
      check("app_rdy", app_rdy, e_rdy);
      check("app_wdf_rdy", app_wdf_rdy, e_wrdy);
      push = wren && e_wrdy;
      acc  = en && e_rdy;
      idx  = int'(addr[10:3]);
      w.data = wd; w.mask = wm;
      if (acc && cmd == 3'b001) m_rdq.push_back('{cyc + LAT, m_mem[idx]});
      if (m_pend) begin
         if (push) begin commit(m_pidx, w); m_pend = 0; end
      end else if (acc && cmd == 3'b000) begin
         if (m_fifo.size() > 0) begin
            commit(idx, m_fifo.pop_front());
            if (push) m_fifo.push_back(w);
         end else if (push) commit(idx, w);
         else begin m_pend = 1; m_pidx = idx; end
      end else if (push) m_fifo.push_back(w);
      if (rf && cyc > ref_due) ref_due = cyc + 2;
      if (zq && cyc > zq_due)  zq_due  = cyc + 2;
      @(posedge clk); #1;
      cyc++;
      observe();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 3'b000, '0, 0, '0, '0);
   endtask

   task automatic do_reset();
      app_en = 0; app_wdf_wren = 0; app_ref_req = 0; app_zq_req = 0;
      reset = 1'b1;
      @(posedge clk); #1; @(posedge clk); #1;
      check("rst_rdy", app_rdy, 0);
      check("rst_wdf_rdy", app_wdf_rdy, 0);
      check("rst_rd_data", app_rd_data, 0);
      check("rst_rd_valid", app_rd_data_valid, 0);
      check("rst_acks", {app_ref_ack, app_zq_ack}, 0);
      check("rst_calib", init_calib_complete, 0);
      reset = 1'b0;
      m_fifo.delete(); m_rdq.delete();
      m_pend = 0; m_last = '0; cyc = 0; ref_due = -10; zq_due = -10;
   endtask

   typedef struct {
      logic [2:0]   cmd;
      logic [26:0]  addr;
      logic [127:0] data;
      logic [15:0]  mask;
      logic [127:0] exp;
   } vec_t;

   initial begin
      vec_t         vecs [9];
      logic [127:0] d;
      logic [3:0]   ri;
      int           r, seen;

      vecs[0] = '{3'b000, 27'h0000010, 128'h00AAAA0000AAAA0000AAAA0000AAAA00, 16'h0000, '0};
      vecs[1] = '{3'b001, 27'h0000010, '0, '0, 128'h00AAAA0000AAAA0000AAAA0000AAAA00};
      vecs[2] = '{3'b000, 27'h0000020, {128{1'b1}}, 16'h0000, '0};
      vecs[3] = '{3'b000, 27'h0000020, 128'h0123456789ABCDEFFEDCBA9876543210, 16'h000F, '0};
      vecs[4] = '{3'b001, 27'h0000020, '0, '0, 128'h0123456789ABCDEFFEDCBA98FFFFFFFF};
      vecs[5] = '{3'b000, 27'h7FF0010, {32{4'h5}}, 16'hFF00, '0};
      vecs[6] = '{3'b001, 27'h0000010, '0, '0, 128'h00AAAA0000AAAA005555555555555555};
      vecs[7] = '{3'b101, 27'h0000010, '0, '0, '0};
      vecs[8] = '{3'b001, 27'h0000017, '0, '0, 128'h00AAAA0000AAAA005555555555555555};

      // Calibration window: commands and data offered but nothing may be accepted.
      do_reset();
      for (int i = 0; i < CAL - 1; i++) cycle(1, 3'b001, 27'h10, 1, 128'hDEAD, 16'h0);
      check("calib_at_63", init_calib_complete, 0);
      check("rdy_at_63", app_rdy, 0);
      idle(1);
      check("calib_at_64", init_calib_complete, 1);
      check("rdy_at_64", app_rdy, 1);
      check("wdf_rdy_at_64", app_wdf_rdy, 1);

      // Directed vectors: writes carry their data in the command cycle, reads checked at fixed latency.
      for (int v = 0; v < 9; v++) begin
         cycle(1, vecs[v].cmd, vecs[v].addr, vecs[v].cmd == 3'b000, vecs[v].data, vecs[v].mask);
         if (vecs[v].cmd == 3'b001) begin
            idle(LAT - 1);
            check($sformatf("vec%0d_valid", v), app_rd_data_valid, 1);
            check($sformatf("vec%0d_data", v), app_rd_data, vecs[v].exp);
            idle(1);
            check($sformatf("vec%0d_hold", v), app_rd_data, vecs[v].exp);
         end
      end

      // Write command two cycles ahead of its data.
      d = 128'hCAFEF00D_12345678_9ABCDEF0_0F1E2D3C;
      cycle(1, 3'b000, 27'h0000040, 0, '0, '0);
      check("pend_rdy_low_1", app_rdy, 0);
      idle(1);
      check("pend_rdy_low_2", app_rdy, 0);
      cycle(0, 3'b000, '0, 1, d, 16'h0);
      check("pend_rdy_back", app_rdy, 1);
      cycle(1, 3'b001, 27'h0000040, 0, '0, '0);
      idle(LAT - 1);
      check("pend_read_data", app_rd_data, d);

      // Refresh/ZQ ack timing; the repeat request during the wait is dropped.
      cycle(0, 3'b000, '0, 0, '0, '0, 1, 1);
      cycle(0, 3'b000, '0, 0, '0, '0, 1, 1);
      check("ref_ack_2", app_ref_ack, 1);
      check("zq_ack_2", app_zq_ack, 1);
      idle(1);
      check("ref_ack_3", app_ref_ack, 0);
      check("zq_ack_3", app_zq_ack, 0);
      idle(2);

      // Randomized traffic over 16 aliased word indices, first initialised in full.
      for (int i = 0; i < 16; i++) cycle(1, 3'b000, 27'(i << 3), 1, {$urandom, $urandom, $urandom, $urandom}, 16'h0);
      for (int i = 0; i < 1500; i++) begin
         ri = 4'($urandom_range(0, 15));
         r  = $urandom_range(0, 9);
         cycle($urandom_range(0, 1) == 1,
               (r < 4) ? 3'b000 : (r < 8) ? 3'b001 : 3'($urandom_range(2, 7)),
               {16'($urandom), 4'b0000, ri, 3'($urandom)},
               $urandom_range(0, 1) == 1,
               {$urandom, $urandom, $urandom, $urandom},
               ($urandom_range(0, 1) == 1) ? 16'h0 : 16'($urandom),
               $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
      end
      idle(LAT + 2);

      // FIFO fill with no commands, then drain by write commands.
      do_reset();
      idle(CAL);
      for (int i = 0; i < 4; i++) cycle(0, 3'b000, '0, 1, {4{32'(i + 1)}}, 16'h0);
      check("fifo_full_wdf_rdy", app_wdf_rdy, 0);
      cycle(0, 3'b000, '0, 1, {4{32'hBAD0BAD0}}, 16'h0);
      for (int i = 0; i < 4; i++) cycle(1, 3'b000, 27'(i << 3), 0, '0, '0);
      cycle(1, 3'b001, 27'h0000018, 0, '0, '0);
      idle(LAT - 1);
      check("fifo_drain_order", app_rd_data, {4{32'h4}});
      idle(1);

      // Reset with two reads in flight: no valid pulse may follow.
      cycle(1, 3'b001, 27'h0, 0, '0, '0);
      cycle(1, 3'b001, 27'h8, 0, '0, '0);
      do_reset();
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         idle(1);
         if (app_rd_data_valid) seen++;
      end
      check("no_valid_after_reset", 32'(seen), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/app_mem_responder.md
APP_MEM_RESPONDER -- requirements
Module: app_mem_responder

Interface
REQ-001 Parameters SHALL be: MEM_DEPTH_LOG2, default 8, log2 of 128-bit words stored; READ_LATENCY, default 4, read accept to data valid in cycles (2..15); CALIB_CYCLES, default 64, cycles from reset release to init_calib_complete.
REQ-002 Ports SHALL be: clk  in  1  single clock; reset  in  1  asynchronous, active-high reset.
REQ-003 Ports SHALL be: app_addr in 27, byte/column address; app_cmd in 3, 000 write, 001 read; app_en in 1, command valid.
REQ-004 Ports SHALL be: app_wdf_data in 128, write data; app_wdf_mask in 16, byte mask (1 = byte not written); app_wdf_wren in 1, data valid; app_wdf_end in 1, last beat.
REQ-005 Ports SHALL be: app_rdy out 1, command accepted; app_wdf_rdy out 1, data accepted; app_rd_data out 128, read data; app_rd_data_valid out 1; app_rd_data_end out 1.
REQ-006 Ports SHALL be: app_ref_req in 1; app_zq_req in 1; app_ref_ack out 1; app_zq_ack out 1; init_calib_complete out 1.

Function
REQ-007 Block SHALL model the responder (memory) side of the DDR2 controller user interface, one 128-bit word per command.
REQ-008 Word index SHALL be app_addr[3 +: MEM_DEPTH_LOG2]; higher address bits are ignored (aliasing), app_addr[2:0] ignored.
REQ-009 Calibration counter SHALL count CALIB_CYCLES clocks after reset release, then set init_calib_complete = 1 until the next reset; app_rdy and app_wdf_rdy SHALL stay 0 before that.
REQ-010 Write-data FIFO, 4 entries: push on app_wdf_wren & app_wdf_rdy; app_wdf_rdy = calib & FIFO not full; app_wdf_end is ignored (one beat per burst).
REQ-011 Command accept SHALL be app_en & app_rdy; app_rdy = calib & no pending write & (BACKPRESSURE not stalling, REQ-022).
REQ-012 Accepted write with FIFO non-empty (or a same-cycle push into empty FIFO, bypass) SHALL commit the head word that cycle, per byte where mask bit = 0; otherwise the write SHALL be held pending and app_rdy = 0 until data arrives, then commit in the cycle the data is available.
REQ-013 Accepted read SHALL sample memory in the accept cycle and present app_rd_data with app_rd_data_valid = app_rd_data_end = 1 exactly READ_LATENCY cycles later, one cycle wide per read.
REQ-014 Back-to-back reads SHALL return in order, one per cycle, no bubbles; the pipeline SHALL have no backpressure.
REQ-015 Write followed by a read of the same index on the next accepted command SHALL return the new data (read-after-write ordering).
REQ-016 app_cmd values other than 000/001 SHALL be accepted and discarded with no memory or pipeline effect.
REQ-017 FIFO full: further app_wdf_wren SHALL be ignored (not pushed) while app_wdf_rdy = 0; data words without a matching write command SHALL remain queued.
REQ-018 app_ref_req / app_zq_req SHALL each produce a one-cycle app_ref_ack / app_zq_ack exactly 2 cycles later; a new req during the wait SHALL be ignored.
REQ-019 app_rd_data SHALL hold its last value when app_rd_data_valid = 0.

Reset
REQ-020 On reset all outputs SHALL be 0 (app_rd_data = 0), FIFO emptied, pending write and read pipeline cleared, calibration counter restarted; memory contents SHALL be preserved.
REQ-021 Reset asserted mid-operation SHALL drop in-flight reads (no valid pulse after release) and discard pending writes.

Configuration
REQ-022 Macro APP_RESP_BACKPRESSURE_EN defined: a free-running 4-bit counter SHALL force app_rdy = 0 for counter values 12..15 (4 of every 16 cycles after calib); undefined: no such stall, counter not built.

Verification
REQ-023 Reset release, CALIB_CYCLES = 64 -> init_calib_complete rises at cycle 64, app_rdy/app_wdf_rdy 0 before.
REQ-024 Write addr 0x000010 data 128'h00AAAA00 x4 mask 16'h0000, then read addr 0x000010 -> app_rd_data = 128'h00AAAA0000AAAA0000AAAA0000AAAA00 exactly 4 cycles after read accept.
REQ-025 Write command two cycles before its data -> app_rdy low until data push, then commit; subsequent read returns that data.
REQ-026 Write with mask 16'h000F over existing all-ones word -> read returns bytes 3:0 = 0xFF preserved, remaining bytes new data.
REQ-027 Five wdf pushes with no commands -> fifth push refused, app_wdf_rdy = 0 after fourth; reset asserted with two reads in flight -> no app_rd_data_valid after release.
REQ-028 With APP_RESP_BACKPRESSURE_EN, continuous app_en reads -> exactly 12 accepts per 16 cycles, data returned in order.
